adsr_envelope: RTL

Per-voice ADSR amplitude envelope. Sits directly downstream of the wavetable harmonic synthesizers: it consumes one 16-bit wavetable sample per sample strobe and scales it by a 16-bit envelope level. The envelope level advances through Attack/Decay/Sustain/Release in response to a key gate. Output feeds the voice mixer.

---
 rtl/synth_pkg.sv | 26 ++
 rtl/env_scaler.sv | 33 +++
 rtl/adsr_envelope.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// ---------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the per-voice synthesis chain (wavetable
// synthesizers, envelope, mixer).
//   SAMPLE_W    : width of signed audio samples
//   ENV_W       : width of unsigned envelope levels and step values
//   ENV_MAX     : full-scale envelope level
//   env_state_t : ADSR envelope state encoding (also exported on the
//                 envelope's state port)
// ---------------------------------------------------------------------------
package synth_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned ENV_W    = 16;

  localparam logic [15:0] ENV_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

endpackage : synth_pkg

// File: rtl/env_scaler.sv
// ---------------------------------------------------------------------------
// env_scaler
// Combinational amplitude scaler: signed sample times unsigned envelope
// level, keeping the upper SAMPLE_W bits of the ENV_W fractional product.
// Kept in its own module so it can be mapped onto a hard multiplier.
//   sample_i : signed sample (SAMPLE_W)
//   level_i  : unsigned level, treated as a 0.ENV_W fraction (ENV_W)
//   scaled_o : product bits [SAMPLE_W+ENV_W-1 : ENV_W] (SAMPLE_W)
// ---------------------------------------------------------------------------
module env_scaler #(
  parameter int unsigned SAMPLE_W = synth_pkg::SAMPLE_W,
  parameter int unsigned ENV_W    = synth_pkg::ENV_W
) (
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic        [ENV_W-1:0]    level_i,
  output logic signed [SAMPLE_W-1:0] scaled_o
);

  import synth_pkg::*;

  // Level is zero-extended by one bit so the multiply stays signed without
  // reinterpreting levels >= half scale as negative.
  logic signed [SAMPLE_W+ENV_W:0] product;
  logic                           unused_bits;

  always_comb begin
    product = sample_i * $signed({1'b0, level_i});
  end

  assign scaled_o    = product[SAMPLE_W+ENV_W-1:ENV_W];
  assign unused_bits = ^{product[SAMPLE_W+ENV_W], product[ENV_W-1:0]};

endmodule : env_scaler

// File: rtl/adsr_envelope.sv
// ---------------------------------------------------------------------------
// adsr_envelope
// Per-voice ADSR amplitude envelope. Advances once per sample strobe and
// scales the incoming wavetable sample by the pre-update envelope level.
//   Clk           : system clock
//   Reset         : synchronous reset, active low
//   sample_Clk    : one-Clk-wide sample strobe; all registers hold otherwise
//   gate          : key held (1) / released (0), sampled on strobes only
//   sample_in     : signed sample from the wavetable synthesizer
//   attack_step   : level increment per strobe in ATTACK
//   decay_step    : level decrement per strobe in DECAY
//   sustain_level : sustain target, read live
//   release_step  : level decrement per strobe in RELEASE
//   out           : registered scaled sample
//   env_level     : registered envelope level
//   busy          : state != IDLE
//   state         : current env_state_t code
// ---------------------------------------------------------------------------
module adsr_envelope #(
  parameter int unsigned SAMPLE_W = synth_pkg::SAMPLE_W,
  parameter int unsigned ENV_W    = synth_pkg::ENV_W
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       sample_Clk,
  input  logic                       gate,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic        [ENV_W-1:0]    attack_step,
  input  logic        [ENV_W-1:0]    decay_step,
  input  logic        [ENV_W-1:0]    sustain_level,
  input  logic        [ENV_W-1:0]    release_step,
  output logic signed [SAMPLE_W-1:0] out,
  output logic        [ENV_W-1:0]    env_level,
  output logic                       busy,
  output logic        [2:0]          state
);

  import synth_pkg::*;

  localparam logic [ENV_W-1:0] LEVEL_MAX = {ENV_W{1'b1}};

  env_state_t                 state_q, state_d;
  logic        [ENV_W-1:0]    level_q, level_d;
  logic signed [SAMPLE_W-1:0] out_q,   out_d;

  // One extra bit on each step result: bit ENV_W is the carry (attack) or
  // borrow (decay/release) that drives saturation.
  logic [ENV_W:0] atk_sum;
  logic [ENV_W:0] dec_diff;
  logic [ENV_W:0] rel_diff;

  assign atk_sum  = {1'b0, level_q} + {1'b0, attack_step};
  assign dec_diff = {1'b0, level_q} - {1'b0, decay_step};
  assign rel_diff = {1'b0, level_q} - {1'b0, release_step};

  env_scaler #(
    .SAMPLE_W (SAMPLE_W),
    .ENV_W    (ENV_W)
  ) u_scaler (
    .sample_i (sample_in),
    .level_i  (level_q),
    .scaled_o (out_d)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      level_q <= '0;
      out_q   <= '0;
    end else if (sample_Clk) begin
      state_q <= state_d;
      level_q <= level_d;
      out_q   <= out_d;
    end
  end

  // Gate transitions take priority and leave the level untouched for that
  // strobe; stepping only happens when no transition fires.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      IDLE: begin
        if (gate) begin
          state_d = ATTACK;
        end else begin
          level_d = '0;
        end
      end

      ATTACK: begin
        if (!gate) begin
          state_d = RELEASE;
        end else if (atk_sum[ENV_W] || (atk_sum[ENV_W-1:0] == LEVEL_MAX)) begin
          level_d = LEVEL_MAX;
          state_d = DECAY;
        end else begin
          level_d = atk_sum[ENV_W-1:0];
        end
      end

      DECAY: begin
        if (!gate) begin
          state_d = RELEASE;
        end else if (level_q <= sustain_level) begin
          level_d = sustain_level;
          state_d = SUSTAIN;
        end else if (dec_diff[ENV_W] || (dec_diff[ENV_W-1:0] <= sustain_level)) begin
          // Clamp at sustain covers both exact landing and overshoot.
          level_d = sustain_level;
          state_d = SUSTAIN;
        end else begin
          level_d = dec_diff[ENV_W-1:0];
        end
      end

      SUSTAIN: begin
        if (!gate) begin
          state_d = RELEASE;
        end else begin
          level_d = sustain_level;
        end
      end

      RELEASE: begin
        if (gate) begin
          // Retrigger continues from the current level.
          state_d = ATTACK;
        end else if (rel_diff[ENV_W] || (rel_diff[ENV_W-1:0] == '0)) begin
          level_d = '0;
          state_d = IDLE;
        end else begin
          level_d = rel_diff[ENV_W-1:0];
        end
      end

      default: begin
        state_d = IDLE;
        level_d = '0;
      end
    endcase
  end

  assign out       = out_q;
  assign env_level = level_q;
  assign busy      = (state_q != IDLE);
  assign state     = state_q;

endmodule : adsr_envelope
